frame_line_reader: RTL and testbench

Reads the display frame store one line at a time and streams the line out as bytes over a valid/ready interface. It sits directly downstream of the display datapath. It drives the datapath's frame-read controls (`readFrame`, `FrameReadIncLine`, `FrameReadResetLine`), captures the 2640-bit `FrameDataOut` line word, and serializes it to the scan-out consumer with line and frame markers.

---
 rtl/frame_line_reader.sv | 238 +++++++++++++++++++++++
 tb/tb_frame_line_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_line_reader.sv
// Purpose : reads the frame store one line at a time and streams each line out as bytes,
//           driving the store's readFrame / FrameReadIncLine / FrameReadResetLine controls.
// Latency : start sampled at edge k -> SYNC in k+1, FETCH for FETCH_LAT cycles, first px_valid in k+2+FETCH_LAT.
// Backpr. : px_valid holds until px_ready; data, markers and line_idx are frozen while stalled.
//
// Ports:
//   clk, reset (async, active-low), start
//   readFrame, FrameReadIncLine, FrameReadResetLine -> frame store controls
//   FrameDataOut                                    <- line word; its leftmost bit is the MSB of byte 0
//   px_data/px_valid/px_ready, px_sol/px_eol/px_eof -> byte stream with line/frame markers
//   line_idx, busy, frame_done                      -> status
// Build option: FRAME_READER_PREFETCH_EN adds a prefetch line register so lines stream back-to-back.
module frame_line_reader #(
  parameter int LINE_BITS = 2640,
  parameter int LINES     = 480,
  parameter int FETCH_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 readFrame,
  output logic                 FrameReadIncLine,
  output logic                 FrameReadResetLine,
  input  logic [LINE_BITS-1:0] FrameDataOut,
  output logic [7:0]           px_data,
  output logic                 px_valid,
  input  logic                 px_ready,
  output logic                 px_sol,
  output logic                 px_eol,
  output logic                 px_eof,
  output logic [9:0]           line_idx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BPL = LINE_BITS / 8;
  localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPL - 1);
  localparam logic [9:0]    LAST_LINE = 10'(LINES - 1);
  localparam logic [3:0]    LAST_CYC  = 4'(FETCH_LAT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, FETCH, SHIFT} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BW-1:0]        byte_q, byte_d;
  logic [9:0]           line_idx_q, line_idx_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [7:0]           px_data_q, px_data_d;
  logic                 px_valid_q, px_valid_d;
  logic                 px_sol_q, px_sol_d, px_eol_q, px_eol_d, px_eof_q, px_eof_d;
  logic                 rd_q, rd_d, inc_q, inc_d, rstl_q, rstl_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 xfer;

`ifdef FRAME_READER_PREFETCH_EN
  logic [LINE_BITS-1:0] pf_q, pf_d;
  logic                 pf_full_q, pf_full_d;
  logic                 pf_act_q, pf_act_d;
  logic [3:0]           pf_cnt_q, pf_cnt_d;
  logic [9:0]           pf_line_q, pf_line_d;   // line the background fetch is reading
  logic                 pf_done;
`endif

  // Byte i occupies the i-th octet counted from the left; its leftmost bit becomes px_data[7].
  function automatic logic [7:0] sel_byte(input logic [LINE_BITS-1:0] w, input logic [BW-1:0] idx);
    return w[LINE_BITS - 1 - 8 * int'(idx) -: 8];
  endfunction

  assign xfer = px_valid_q && px_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    line_idx_d = line_idx_q;
    line_d     = line_q;
    px_valid_d = px_valid_q;
    done_d     = 1'b0;
`ifdef FRAME_READER_PREFETCH_EN
    pf_d      = pf_q;
    pf_full_d = pf_full_q;
    pf_act_d  = pf_act_q;
    pf_cnt_d  = pf_cnt_q;
    pf_line_d = pf_line_q;
    pf_done   = pf_act_q && (pf_cnt_q == LAST_CYC);
    if (pf_act_q) begin
      if (pf_done) pf_act_d = 1'b0;
      else         pf_cnt_d = pf_cnt_q + 4'd1;
    end
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d    = SYNC;
        line_idx_d = '0;
      end
      SYNC: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        if (cnt_q == LAST_CYC) begin
          line_d     = FrameDataOut;
          byte_d     = '0;
          px_valid_d = 1'b1;
          state_d    = SHIFT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SHIFT: begin
`ifdef FRAME_READER_PREFETCH_EN
        // A late background fetch either feeds a stalled line start directly or fills the prefetch slot.
        if (pf_done && !px_valid_q) begin
          line_d     = FrameDataOut;
          byte_d     = '0;
          px_valid_d = 1'b1;
        end else if (pf_done) begin
          pf_d      = FrameDataOut;
          pf_full_d = 1'b1;
        end
`endif
        if (xfer) begin
          if (byte_q != LAST_BYTE) begin
            byte_d = byte_q + 1'b1;
          end else if (line_idx_q == LAST_LINE) begin
            state_d    = IDLE;
            px_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            line_idx_d = line_idx_q + 10'd1;
            byte_d     = '0;
`ifdef FRAME_READER_PREFETCH_EN
            if (pf_full_q) begin
              line_d    = pf_q;
              pf_full_d = 1'b0;
            end else if (pf_done) begin
              line_d    = FrameDataOut;
              pf_full_d = 1'b0;
            end else begin
              px_valid_d = 1'b0;
            end
`else
            state_d    = FETCH;
            cnt_d      = '0;
            px_valid_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FRAME_READER_PREFETCH_EN
    // Keep one line ahead: launch a background read whenever the slot is empty and lines remain.
    if (state_d == SHIFT && !pf_act_d && !pf_full_d && line_idx_d != LAST_LINE) begin
      pf_act_d  = 1'b1;
      pf_cnt_d  = '0;
      pf_line_d = line_idx_d + 10'd1;
    end
`endif
    px_data_d = px_valid_d ? sel_byte(line_d, byte_d) : 8'h00;
    px_sol_d  = px_valid_d && (byte_d == '0);
    px_eol_d  = px_valid_d && (byte_d == LAST_BYTE);
    px_eof_d  = px_eol_d && (line_idx_d == LAST_LINE);
    rstl_d    = (state_d == SYNC);
    busy_d    = (state_d != IDLE);
    // The last line of a frame never advances the store counter; the next SYNC clears it.
    rd_d      = (state_d == FETCH);
    inc_d     = (state_d == FETCH) && (cnt_d == LAST_CYC) && (line_idx_d != LAST_LINE);
`ifdef FRAME_READER_PREFETCH_EN
    rd_d  = rd_d || pf_act_d;
    inc_d = inc_d || (pf_act_d && (pf_cnt_d == LAST_CYC) && (pf_line_d != LAST_LINE));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      line_idx_q <= '0;
      line_q     <= '0;
      px_data_q  <= '0;
      px_valid_q <= 1'b0;
      px_sol_q   <= 1'b0;
      px_eol_q   <= 1'b0;
      px_eof_q   <= 1'b0;
      rd_q       <= 1'b0;
      inc_q      <= 1'b0;
      rstl_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FRAME_READER_PREFETCH_EN
      pf_q       <= '0;
      pf_full_q  <= 1'b0;
      pf_act_q   <= 1'b0;
      pf_cnt_q   <= '0;
      pf_line_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      line_idx_q <= line_idx_d;
      line_q     <= line_d;
      px_data_q  <= px_data_d;
      px_valid_q <= px_valid_d;
      px_sol_q   <= px_sol_d;
      px_eol_q   <= px_eol_d;
      px_eof_q   <= px_eof_d;
      rd_q       <= rd_d;
      inc_q      <= inc_d;
      rstl_q     <= rstl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef FRAME_READER_PREFETCH_EN
      pf_q       <= pf_d;
      pf_full_q  <= pf_full_d;
      pf_act_q   <= pf_act_d;
      pf_cnt_q   <= pf_cnt_d;
      pf_line_q  <= pf_line_d;
`endif
    end
  end

  assign readFrame          = rd_q;
  assign FrameReadIncLine   = inc_q;
  assign FrameReadResetLine = rstl_q;
  assign px_data            = px_data_q;
  assign px_valid           = px_valid_q;
  assign px_sol             = px_sol_q;
  assign px_eol             = px_eol_q;
  assign px_eof             = px_eof_q;
  assign line_idx           = line_idx_q;
  assign busy               = busy_q;
  assign frame_done         = done_q;

endmodule

// File: tb/tb_frame_line_reader.sv
`timescale 1ns/1ps
module tb_frame_line_reader;

  localparam int LB = 32;
  localparam int LN = 4;
  localparam int FL = 1;
`ifdef FRAME_READER_PREFETCH_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = FL;
`endif

  typedef struct packed {
    logic [9:0] line;
    logic       sol;
    logic       eol;
    logic       eof;
    logic [7:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, start, px_ready;
  logic          readFrame, FrameReadIncLine, FrameReadResetLine;
  logic [LB-1:0] FrameDataOut;
  logic [7:0]    px_data;
  logic          px_valid, px_sol, px_eol, px_eof, busy, frame_done;
  logic [9:0]    line_idx;

  int         checks = 0;
  int         failures = 0;
  beat_t      sb[$];
  int         cyc = 0;
  int         inc_cnt = 0;
  int         done_cnt = 0;
  int         rdy_mode = 0;
  logic [9:0] store_ctr = '0;

  // Monitor-private state
  logic  hold_vld = 1'b0;
  beat_t held;
  logic  exp_done = 1'b0;
  logic  gap_pending = 1'b0;
  int    gap_cnt = 0;

  frame_line_reader #(.LINE_BITS(LB), .LINES(LN), .FETCH_LAT(FL)) dut (
    .clk(clk), .reset(reset), .start(start),
    .readFrame(readFrame), .FrameReadIncLine(FrameReadIncLine), .FrameReadResetLine(FrameReadResetLine),
    .FrameDataOut(FrameDataOut),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_sol(px_sol), .px_eol(px_eol), .px_eof(px_eof),
    .line_idx(line_idx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame store: line n holds bytes n, n+1, n+2, n+3 (leftmost first).
  assign FrameDataOut = {8'(store_ctr), 8'(store_ctr + 10'd1), 8'(store_ctr + 10'd2), 8'(store_ctr + 10'd3)};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (FrameReadResetLine)    store_ctr <= '0;
    else if (FrameReadIncLine) store_ctr <= store_ctr + 10'd1;
    if (FrameReadIncLine) inc_cnt <= inc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {5'b0, readFrame, FrameReadIncLine, FrameReadResetLine, px_data, px_valid,
            px_sol, px_eol, px_eof, line_idx, busy, frame_done};
  endfunction

  // Scoreboard monitor: compares every transferred byte, stall stability, gaps and frame_done.
  always @(negedge clk) begin
    beat_t cur, exp;
    cur = {line_idx, px_sol, px_eol, px_eof, px_data};
    if (!reset) begin
      hold_vld    = 1'b0;
      exp_done    = 1'b0;
      gap_pending = 1'b0;
    end else begin
      if (exp_done || frame_done) check("frame_done", {31'b0, frame_done}, {31'b0, exp_done});
      if (frame_done) done_cnt++;
      exp_done = 1'b0;
      if (px_valid) begin
        if (hold_vld) check("stall_stable", cur, held);
        if (gap_pending) begin
          check("line_gap", gap_cnt, EXP_GAP);
          gap_pending = 1'b0;
        end
        if (px_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_byte", cur, 0);
          end else begin
            exp = sb.pop_front();
            check("beat", cur, exp);
          end
          if (px_eol && !px_eof) begin
            gap_pending = 1'b1;
            gap_cnt     = 0;
          end
          if (px_eof) exp_done = 1'b1;
          hold_vld = 1'b0;
        end else begin
          hold_vld = 1'b1;
          held     = cur;
        end
      end else begin
        if (hold_vld) check("valid_held", {31'b0, px_valid}, 1);
        hold_vld = 1'b0;
        if (gap_pending) gap_cnt++;
      end
    end
  end

  // Ready driver: always ready, or ready one cycle in three.
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  task automatic push_frame();
    for (int n = 0; n < LN; n++) begin
      for (int i = 0; i < 4; i++) begin
        beat_t b;
        b.line = 10'(n);
        b.sol  = (i == 0);
        b.eol  = (i == 3);
        b.eof  = (i == 3) && (n == LN - 1);
        b.data = 8'(n + i);
        sb.push_back(b);
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int base_done);
    int n;
    n = 0;
    while (done_cnt == base_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, done_cnt - base_done, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   base_inc, base_done;
    logic found;
    logic [31:0] acc;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", outs(), 0);
    @(negedge clk);
    reset = 1'b1;

    // Frame 1: start latency, full ready, marker placement and pulse count.
    repeat (2) @(posedge clk);
    base_inc  = inc_cnt;
    base_done = done_cnt;
    push_frame();
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk); check("sync_cycle",  {28'b0, readFrame, FrameReadResetLine, px_valid, busy}, 32'b0101);
    @(negedge clk); check("fetch_cycle", {29'b0, readFrame, FrameReadResetLine, px_valid}, 32'b100);
    @(negedge clk); check("first_valid", {30'b0, FrameReadResetLine, px_valid}, 32'b01);
    wait_frame("frame1_done", base_done);
    check("frame1_inc_pulses", inc_cnt - base_inc, 3);
    check("frame1_sb_empty", sb.size(), 0);

    // Frame 2: 1-of-3 backpressure, with start pulsed again while busy.
    rdy_mode  = 1;
    base_inc  = inc_cnt;
    base_done = done_cnt;
    push_frame();
    pulse_start();
    repeat (15) @(posedge clk);
    #1 check("busy_mid_frame", {31'b0, busy}, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_frame("frame2_done", base_done);
    check("frame2_inc_pulses", inc_cnt - base_inc, 3);
    check("frame2_sb_empty", sb.size(), 0);
    acc = '0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | {31'b0, busy};
    end
    check("idle_after_frame", acc, 0);

    // Frame 3: reset in the middle of line 2, then a clean restart.
    rdy_mode = 0;
    push_frame();
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (px_valid && line_idx == 10'd2 && !px_sol) found = 1'b1;
    end
    check("reach_line2", {31'b0, found}, 1);
    #2 reset = 1'b0;
    #1 check("midframe_reset_outputs", outs(), 0);
    repeat (3) @(negedge clk);
    sb.delete();
    reset = 1'b1;
    acc = '0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | {28'b0, readFrame, FrameReadIncLine, FrameReadResetLine, px_valid};
    end
    check("quiet_after_reset", acc, 0);
    base_inc  = inc_cnt;
    base_done = done_cnt;
    push_frame();
    pulse_start();
    wait_frame("frame3_done", base_done);
    check("frame3_inc_pulses", inc_cnt - base_inc, 3);
    check("frame3_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
